// File: rtl/awmc_pkg.sv
// awmc_pkg: stage codes, default stage durations and duration normalisation for the wash FSM
package awmc_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WASH  = 3'd2,
    RINSE = 3'd3,
    DRAIN = 3'd4,
    SPIN  = 3'd5,
    DONE  = 3'd6
  } stage_t;
  localparam int FILL_DEF  = 4;
  localparam int WASH_DEF  = 6;
  localparam int RINSE_DEF = 4;
  localparam int DRAIN_DEF = 3;
  localparam int SPIN_DEF  = 5;
  // a zero duration still occupies one cycle
  function automatic logic [15:0] eff_cyc(input int n);
    return (n <= 0) ? 16'd1 : n[15:0];
  endfunction
endpackage

// File: rtl/awmc_stage_timer.sv
// awmc_stage_timer: per-stage cycle counter with clear/enable/hold and expiry compare
module awmc_stage_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] dur,
  output logic        expired
);
  logic [15:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 16'd1;
  assign expired = cnt == dur - 16'd1;
endmodule

// File: rtl/awmc_fsm.sv
// awmc_fsm: washing-machine cycle sequencer IDLE-FILL-WASH-RINSE-DRAIN-SPIN-DONE with pause
module awmc_fsm
  import awmc_pkg::*;
#(
  parameter int FILL_CYC  = FILL_DEF,
  parameter int WASH_CYC  = WASH_DEF,
  parameter int RINSE_CYC = RINSE_DEF,
  parameter int DRAIN_CYC = DRAIN_DEF,
  parameter int SPIN_CYC  = SPIN_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  output logic [2:0] stage,
  output logic       done
);
  localparam logic [15:0] DF = eff_cyc(FILL_CYC);
  localparam logic [15:0] DW = eff_cyc(WASH_CYC);
  localparam logic [15:0] DR = eff_cyc(RINSE_CYC);
  localparam logic [15:0] DD = eff_cyc(DRAIN_CYC);
  localparam logic [15:0] DS = eff_cyc(SPIN_CYC);
  stage_t      state, state_n;
  logic [15:0] dur;
  logic        expired, timed;
  assign timed = state inside {FILL, WASH, RINSE, DRAIN, SPIN};
  always_comb begin
    dur = state == FILL  ? DF :
          state == WASH  ? DW :
          state == RINSE ? DR :
          state == DRAIN ? DD : DS;
  end
  // pause outranks start and expiry; code 7 falls through to IDLE
  always_comb begin
    state_n = state;
    state_n = pause ? state :
              (state == IDLE || state == DONE) ? (start ? FILL : state) :
              timed ? (expired ? stage_t'(state + 3'd1) : state) : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      done  <= state_n == DONE;
    end
  assign stage = state;
  awmc_stage_timer u_tmr (
    .clk    (clk),
    .reset  (reset),
    .clr    (state_n != state),
    .en     (timed && !pause),
    .dur    (dur),
    .expired(expired)
  );
endmodule

// File: tb/tb_awmc_fsm.sv
// tb_awmc_fsm: directed scoreboard bench for awmc_fsm timing, pause, start and reset behaviour
module tb_awmc_fsm;
  logic       clk = 1'b0;
  logic       reset, start, pause;
  logic       reset2, start2;
  logic [2:0] stage, stage2;
  logic       done, done2;
  logic [3:0] sb[$];
  logic [3:0] e;
  int         checks = 0;
  int         fails = 0;
  always #5 clk = ~clk;
  awmc_fsm dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .pause(pause),
    .stage(stage),
    .done (done)
  );
  awmc_fsm #(.WASH_CYC(0)) dut2 (
    .clk  (clk),
    .reset(reset2),
    .start(start2),
    .pause(1'b0),
    .stage(stage2),
    .done (done2)
  );
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input string tag, input logic s, input logic p, input logic [2:0] es, input logic ed);
    start = s;
    pause = p;
    sb.push_back({es, ed});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(tag, {12'd0, stage, done}, {12'd0, e});
  endtask
  task automatic run(input string tag, input int n, input logic s, input logic p, input logic [2:0] es, input logic ed);
    for (int i = 0; i < n; i++) step(tag, s, p, es, ed);
  endtask
  initial begin
    reset = 1'b0; start = 1'b0; pause = 1'b0;
    reset2 = 1'b1; start2 = 1'b0;
    #2 reset = 1'b1;
    #2 check("reset_async", {12'd0, stage, done}, 16'h0000);
    @(posedge clk); #1 reset = 1'b0;
    check("reset_timer", dut.u_tmr.cnt, 16'd0);
    // nominal run, start held for two edges
    step("a_start", 1, 0, 1, 0);
    run("a_fill_held", 1, 1, 0, 1, 0);
    run("a_fill", 2, 0, 0, 1, 0);
    run("a_wash", 6, 0, 0, 2, 0);
    run("a_rinse", 4, 0, 0, 3, 0);
    run("a_drain", 3, 0, 0, 4, 0);
    run("a_spin", 5, 0, 0, 5, 0);
    run("a_done", 4, 0, 0, 6, 1);
    // pause in WASH, start pulse in RINSE, restart from DONE
    step("b_start", 1, 0, 1, 0);
    run("b_fill", 3, 0, 0, 1, 0);
    run("b_wash0", 3, 0, 0, 2, 0);
    check("b_timer_pre", dut.u_tmr.cnt, 16'd2);
    run("b_paused", 10, 1, 1, 2, 0);
    check("b_timer_frozen", dut.u_tmr.cnt, 16'd2);
    run("b_wash1", 3, 0, 0, 2, 0);
    step("b_rinse_start", 1, 0, 3, 0);
    run("b_rinse_pulse", 1, 1, 0, 3, 0);
    run("b_rinse", 2, 0, 0, 3, 0);
    run("b_drain", 3, 0, 0, 4, 0);
    run("b_spin", 5, 0, 0, 5, 0);
    run("b_done", 3, 0, 0, 6, 1);
    step("b_restart", 1, 0, 1, 0);
    check("b_restart_timer", dut.u_tmr.cnt, 16'd0);
    // reset between edges during SPIN while paused
    run("c_fill", 3, 0, 0, 1, 0);
    run("c_wash", 6, 0, 0, 2, 0);
    run("c_rinse", 4, 0, 0, 3, 0);
    run("c_drain", 3, 0, 0, 4, 0);
    run("c_spin", 2, 0, 0, 5, 0);
    pause = 1'b1;
    #3 reset = 1'b1;
    #1 check("c_reset_mid", {12'd0, stage, done}, 16'h0000);
    check("c_reset_timer", dut.u_tmr.cnt, 16'd0);
    @(posedge clk); #1 reset = 1'b0;
    run("c_idle", 3, 0, 0, 0, 0);
    // start and pause together in IDLE
    run("d_start_paused", 3, 1, 1, 0, 0);
    step("d_unpause", 1, 0, 1, 0);
    // start held across reset release
    #2 reset = 1'b1;
    #2 check("e_reset", {12'd0, stage, done}, 16'h0000);
    reset = 1'b0;
    step("e_start_held", 1, 0, 1, 0);
    start = 1'b0;
    // WASH_CYC=0 stretches to one cycle
    @(posedge clk); #1;
    reset2 = 1'b0;
    start2 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      sb.push_back({(i < 4) ? 3'd1 : (i == 4) ? 3'd2 : 3'd3, 1'b0});
      @(posedge clk); #1;
      start2 = 1'b0;
      e = sb.pop_front();
      check("f_wash0", {12'd0, stage2, done2}, {12'd0, e});
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
